// File: rtl/seven_seg_scan.sv
// Multiplexed scanner for a common-anode seven-segment display: double-buffered nibbles,
// prescaled digit slots, dead time, leading-zero suppression and per-digit decimal points.
module seven_seg_scan #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 1000,
   parameter int DEAD       = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          load,
   input  logic [4*NUM_DIGITS-1:0]       digits_in,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   input  logic                          lz_en,
   output logic [3:0]                    Out,
   output logic                          dp,
   output logic [NUM_DIGITS-1:0]         an,
   output logic                          blank,
   output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
   output logic                          frame_tick
);

   localparam int IW = $clog2(NUM_DIGITS);
   localparam int PW = $clog2(PRESCALE);

   logic [PW-1:0]                 pcnt;
   logic [NUM_DIGITS-1:0][3:0]    act_dig;
   logic [NUM_DIGITS-1:0][3:0]    pend_dig;
   logic [NUM_DIGITS-1:0]         act_dp;
   logic [NUM_DIGITS-1:0]         pend_dp;
   logic                          pend_valid;
   logic                          lz_q;
   logic                          slot_end;
   logic                          frame_wrap;
   logic [NUM_DIGITS-1:0]         supp;
   logic                          lit;

   assign slot_end   = enable && (pcnt == PW'(PRESCALE - 1));
   assign frame_wrap = slot_end && (digit_idx == IW'(NUM_DIGITS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt       <= '0;
         digit_idx  <= '0;
         frame_tick <= 1'b0;
         lz_q       <= 1'b0;
      end else begin
         lz_q       <= lz_en;
         frame_tick <= frame_wrap;
         if (enable) begin
            if (slot_end) begin
               pcnt <= '0;
               if (frame_wrap) digit_idx <= '0;
               else            digit_idx <= digit_idx + 1'b1;
            end else begin
               pcnt <= pcnt + 1'b1;
            end
         end
      end
   end

   // Active buffer only changes on the frame wrap, so a frame never mixes old and new data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_dig    <= '0;
         act_dp     <= '0;
         pend_dig   <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
      end else if (frame_wrap) begin
         pend_valid <= 1'b0;
         if (load) begin
            act_dig <= digits_in;
            act_dp  <= dp_in;
         end else if (pend_valid) begin
            act_dig <= pend_dig;
            act_dp  <= pend_dp;
         end
      end else if (load) begin
         pend_dig   <= digits_in;
         pend_dp    <= dp_in;
         pend_valid <= 1'b1;
      end
   end

   // A digit is suppressed when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      supp     = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (act_dig[i] == 4'h0);
         supp[i]  = lz_q & zero_run & (i != 0);
      end
   end

   always_comb begin
      lit   = enable & ~rst & (pcnt >= PW'(DEAD)) & ~supp[digit_idx];
      Out   = act_dig[digit_idx];
      dp    = lit & act_dp[digit_idx];
      blank = ~lit;
      an    = '1;
      if (lit) an[digit_idx] = 1'b0;
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (4 digits, 4-cycle slots, 1 dead cycle): a table for one
// full frame plus hand-written sequences for suppression, wrap-edge loads, enable and reset.
module tb_seven_seg_scan;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        lz_en;
   logic [3:0]  Out;
   logic        dp;
   logic [3:0]  an;
   logic        blank;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   int n_chk  = 0;
   int n_fail = 0;
   int k      = 0;

   typedef struct {
      logic        ld;
      logic [15:0] din;
      logic [3:0]  dpin;
      logic        lz;
      logic [1:0]  idx;
      logic [3:0]  out;
      logic [3:0]  an;
      logic        bl;
      logic        dp;
      logic        ft;
   } vec_t;

   vec_t tbl [16];

   seven_seg_scan #(
      .NUM_DIGITS (4),
      .PRESCALE   (4),
      .DEAD       (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .lz_en      (lz_en),
      .Out        (Out),
      .dp         (dp),
      .an         (an),
      .blank      (blank),
      .digit_idx  (digit_idx),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (k=%0d): got %h, expected %h", nm, k, got, exp);
      end
   endtask

   task automatic disp(input string nm, input logic [1:0] idx, input logic [3:0] out,
                       input logic [3:0] an_e, input logic bl, input logic dp_e, input logic ft);
      chk({nm, ".idx"}, 16'(digit_idx), 16'(idx));
      chk({nm, ".out"}, 16'(Out), 16'(out));
      chk({nm, ".an"}, 16'(an), 16'(an_e));
      chk({nm, ".blank"}, 16'(blank), 16'(bl));
      chk({nm, ".dp"}, 16'(dp), 16'(dp_e));
      chk({nm, ".ft"}, 16'(frame_tick), 16'(ft));
   endtask

   // Advance to the falling edge that follows the t-th rising edge since reset release.
   task automatic to_k(input int t);
      while (k < t) begin
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      // Frame 1 after loading 1234 / dp 0100; last entry loads 0070 on the wrap edge.
      tbl[0]  = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd0, 4'h4, 4'b1111, 1'b1, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd0, 4'h4, 4'b1110, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd0, 4'h4, 4'b1110, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd0, 4'h4, 4'b1110, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd1, 4'h3, 4'b1111, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd1, 4'h3, 4'b1101, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd1, 4'h3, 4'b1101, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd1, 4'h3, 4'b1101, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd2, 4'h2, 4'b1111, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd2, 4'h2, 4'b1011, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd2, 4'h2, 4'b1011, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd2, 4'h2, 4'b1011, 1'b0, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd3, 4'h1, 4'b1111, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd3, 4'h1, 4'b0111, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 16'h0, 4'h0, 1'b0, 2'd3, 4'h1, 4'b0111, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 16'h0070, 4'hF, 1'b1, 2'd3, 4'h1, 4'b0111, 1'b0, 1'b0, 1'b0};

      rst       = 1'b0;
      enable    = 1'b0;
      load      = 1'b0;
      digits_in = '0;
      dp_in     = '0;
      lz_en     = 1'b0;

      // Reset asserted between edges takes effect immediately.
      @(negedge clk);
      @(negedge clk);
      #3 rst = 1'b1;
      #1 disp("rst_async", 2'd0, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst    = 1'b0;
      enable = 1'b1;
      k      = 0;
      #1 disp("slot0_dead", 2'd0, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 4; i++) begin
         to_k(i);
         #1 disp("slot0_lit", 2'd0, 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0);
      end

      // Mid-frame load stays pending until the wrap.
      to_k(5);
      load      = 1'b1;
      digits_in = 16'h1234;
      dp_in     = 4'b0100;
      for (int i = 6; i < 16; i++) begin
         to_k(i);
         load = 1'b0;
         #1;
         chk("no_tear.out", 16'(Out), 16'h0);
         chk("no_tear.ft", 16'(frame_tick), 16'h0);
      end

      for (int e = 0; e < 16; e++) begin
         to_k(16 + e);
         load      = tbl[e].ld;
         digits_in = tbl[e].din;
         dp_in     = tbl[e].dpin;
         lz_en     = tbl[e].lz;
         #1 disp($sformatf("frame1[%0d]", e), tbl[e].idx, tbl[e].out, tbl[e].an, tbl[e].bl,
                 tbl[e].dp, tbl[e].ft);
      end

      // 0070 with suppression: slots 3 and 2 dark, suppressed dp off.
      to_k(32);
      load = 1'b0;
      #1 disp("lz_wrap", 2'd0, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b1);
      to_k(33);
      #1 disp("lz_d0", 2'd0, 4'h0, 4'b1110, 1'b0, 1'b1, 1'b0);
      to_k(37);
      #1 disp("lz_d1", 2'd1, 4'h7, 4'b1101, 1'b0, 1'b1, 1'b0);
      to_k(41);
      #1 disp("lz_d2", 2'd2, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
      to_k(42);
      load      = 1'b1;
      digits_in = 16'h0000;
      dp_in     = 4'b0000;
      to_k(43);
      load = 1'b0;
      to_k(45);
      #1 disp("lz_d3", 2'd3, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0);

      // All-zero buffer: only digit 0 lights.
      to_k(49);
      #1 disp("zero_d0", 2'd0, 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0);
      to_k(53);
      #1 disp("zero_d1", 2'd1, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
      to_k(57);
      #1 disp("zero_d2", 2'd2, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
      to_k(61);
      #1 disp("zero_d3", 2'd3, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0);

      // Load on the wrap edge goes straight to active; the next load waits a frame.
      to_k(63);
      load      = 1'b1;
      digits_in = 16'hABCD;
      lz_en     = 1'b0;
      to_k(64);
      digits_in = 16'h9876;
      #1 chk("wrapload.ft", 16'(frame_tick), 16'h1);
      to_k(65);
      load = 1'b0;
      #1 disp("wrapload_d0", 2'd0, 4'hD, 4'b1110, 1'b0, 1'b0, 1'b0);
      to_k(69);
      #1 disp("wrapload_d1", 2'd1, 4'hC, 4'b1101, 1'b0, 1'b0, 1'b0);
      to_k(73);
      #1 disp("wrapload_d2", 2'd2, 4'hB, 4'b1011, 1'b0, 1'b0, 1'b0);
      to_k(77);
      #1 disp("wrapload_d3", 2'd3, 4'hA, 4'b0111, 1'b0, 1'b0, 1'b0);
      to_k(80);
      #1 chk("second.ft", 16'(frame_tick), 16'h1);
      to_k(81);
      #1 disp("second_d0", 2'd0, 4'h6, 4'b1110, 1'b0, 1'b0, 1'b0);
      to_k(85);
      #1 disp("second_d1", 2'd1, 4'h7, 4'b1101, 1'b0, 1'b0, 1'b0);

      // Disable for 10 cycles mid slot 2; a load meanwhile only reaches pending.
      for (int i = 90; i < 100; i++) begin
         to_k(i);
         enable = 1'b0;
         load   = (i == 92);
         if (i == 92) digits_in = 16'h5555;
         #1 disp("disabled", 2'd2, 4'h8, 4'b1111, 1'b1, 1'b0, 1'b0);
      end
      to_k(100);
      enable = 1'b1;
      #1 disp("resume_p2", 2'd2, 4'h8, 4'b1011, 1'b0, 1'b0, 1'b0);
      to_k(101);
      #1 disp("resume_p3", 2'd2, 4'h8, 4'b1011, 1'b0, 1'b0, 1'b0);
      to_k(102);
      #1 disp("resume_s3", 2'd3, 4'h9, 4'b1111, 1'b1, 1'b0, 1'b0);
      to_k(103);
      #1 disp("resume_s3l", 2'd3, 4'h9, 4'b0111, 1'b0, 1'b0, 1'b0);
      to_k(106);
      #1 disp("resume_wrap", 2'd0, 4'h5, 4'b1111, 1'b1, 1'b0, 1'b1);

      // Reset during slot 3 with pending data discards everything.
      to_k(108);
      load      = 1'b1;
      digits_in = 16'h2222;
      to_k(109);
      load = 1'b0;
      to_k(119);
      #2 rst = 1'b1;
      #1 disp("rst_mid", 2'd0, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
      to_k(120);
      rst = 1'b0;
      #1 disp("post_rst0", 2'd0, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0);
      to_k(121);
      #1 disp("post_rst1", 2'd0, 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0);
      to_k(136);
      #1 disp("post_rst_wrap", 2'd0, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b1);
      to_k(137);
      #1 disp("post_rst_d0", 2'd0, 4'h0, 4'b1110, 1'b0, 1'b0, 1'b0);
      to_k(141);
      #1 chk("post_rst_d1.out", 16'(Out), 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
